q_table_ram: RTL and testbench
==============================

// Module: q_table_ram
// PURPOSE
//  Parametrised Q-table store, successor to the single-channel action RAM.
//  Holds N_ACT signed action values per state and writes one (state, action) entry per cycle.
//  A read returns all N_ACT values of a state plus the greedy action (argmax) and its value.
//  Sits between the Q-update datapath (write side) and the action-selection policy (read side).
// PARAMETERS
//  DATA_W  16  width of one signed (two's complement) Q-value
//  ADDR_W  6   state address width; DEPTH = 2**ADDR_W states
//  N_ACT   4   actions per state (>=2)
//  ACT_W   2   action index width, = $clog2(N_ACT)
// PORTS
//  clk         in   1             rising-edge clock
//  rst         in   1             synchronous reset, active-high
//  en          in   1             block enable; 0 = ignore rd_en/wr_en this cycle
//  wr_en       in   1             write request
//  wr_addr     in   ADDR_W        write state index
//  wr_act      in   ACT_W         write action index
//  wr_data     in   DATA_W        signed value to store
//  rd_en       in   1             read request
//  rd_addr     in   ADDR_W        read state index
//  rd_valid    out  1             rd_* outputs valid this cycle (1-cycle pulse per request)
//  rd_data     out  N_ACT*DATA_W  all action values; action k at [k*DATA_W +: DATA_W]
//  rd_max_val  out  DATA_W        largest value among the N_ACT entries (signed compare)
//  rd_max_act  out  ACT_W         index of rd_max_val
//  busy        out  1             clear sweep in progress; requests ignored
// BEHAVIOUR
//  - Reset: rd_valid=0, rd_data=0, rd_max_val=0, rd_max_act=0, pipeline flushed.
//    Memory contents are untouched by reset unless QRAM_CLEAR_EN is defined.
//  - Write: accepted when en & wr_en & !busy; updates only entry (wr_addr, wr_act) at the clock edge.
//  - Read: accepted when en & rd_en & !busy. It passes through 2 pipeline stages and has a fixed latency of 2.
//    S1 (edge 1): registers the row {N_ACT values} of rd_addr.
//    S2 (edge 2): registers rd_data, the argmax result and rd_valid=1.
//  - One read can be accepted every cycle (full throughput); rd_valid mirrors accepted requests delayed by 2.
//  - Simultaneous read and write to the same state in the same cycle: write-first.
//    S1 captures the new wr_data for wr_act, and the other actions keep their old values.
//  - A write that lands after S1 has captured a row is not reflected in that read.
//  - Argmax: signed compare. On a tie, the lowest action index wins, and it is deterministic.
//    Example: all-equal row -> rd_max_act=0.
//  - en=0: no new request accepted. The pipeline keeps draining, so a read already in S1 still completes.
//    rd_data, rd_max_val and rd_max_act hold their value when rd_valid=0.
//  - Addresses wrap naturally at DEPTH. There is no out-of-range condition.
// CONFIGURATION
//  Macro QRAM_CLEAR_EN:
//   defined: FSM {IDLE, CLEAR}. rst forces CLEAR with sweep pointer 0. rst mid-sweep restarts at 0.
//     In CLEAR, one state per cycle has all N_ACT entries set to 0, with busy=1.
//     After pointer DEPTH-1 is written, the FSM goes to IDLE and busy=0.
//     busy is high for DEPTH cycles after rst deasserts. rd_en/wr_en are ignored while busy.
//   undefined: no FSM, busy tied 0, memory power-up contents undefined.
//     Requests are accepted from the first cycle after rst.
// TESTING
//  1 write (addr 5, act 0..3) = 10,-3,7,10, then read 5 -> rd_valid at +2; rd_data={10,7,-3,10}
//    (act3..0), max_val=10, max_act=0 (tie).
//  2 same-cycle wr(addr 9, act 2, 0x7FFF) + rd 9 (old row 0s) -> row {0,0x7FFF,0,0}, max_act=2.
//  3 back-to-back reads of addr 1,2,3 on 3 cycles -> rd_valid high 3 cycles in order; no bubbles.
//  4 rd_en with en=0 -> no rd_valid; a read accepted one cycle earlier still returns at +2.
//  5 negative values only: -1,-32768,-2,-5 -> max_val=-1, max_act=0.
//  6 [QRAM_CLEAR_EN] rst for 1 cycle -> busy=1 for 64 cycles; wr during busy dropped;
//    after busy falls, read any address -> all zeros, max_act=0.
//    rst at sweep cycle 30 -> busy 64 more cycles.

Source files
------------

// File: rtl/q_table_ram.sv
// q_table_ram: Q-table store holding N_ACT signed action values per state.
// One (state, action) write per cycle; a read returns the whole row plus
// argmax (value and lowest-index action on ties) with a fixed 2-cycle latency.
// Optional feature macro: QRAM_CLEAR_EN (reset-triggered zeroing sweep, busy output).
module q_table_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6,
    parameter int N_ACT  = 4,
    parameter int ACT_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [ACT_W-1:0]        wr_act,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_valid,
    output logic [N_ACT*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]       rd_max_val,
    output logic [ACT_W-1:0]        rd_max_act,
    output logic                    busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH][N_ACT];

    logic busy_w;
    logic wr_acc;
    logic rd_acc;

    logic                     s1_valid_d, s1_valid_q;
    logic signed [DATA_W-1:0] s1_row_d [N_ACT];
    logic signed [DATA_W-1:0] s1_row_q [N_ACT];

    logic signed [DATA_W-1:0] max_val_c;
    logic [ACT_W-1:0]         max_act_c;

    logic                     rd_valid_d, rd_valid_q;
    logic [N_ACT*DATA_W-1:0]  rd_data_d, rd_data_q;
    logic [DATA_W-1:0]        rd_max_val_d, rd_max_val_q;
    logic [ACT_W-1:0]         rd_max_act_d, rd_max_act_q;

`ifdef QRAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_d, state_q;
    logic [ADDR_W-1:0] clr_ptr_d, clr_ptr_q;
    logic              clr_we;

    // Clear sweep sequencing: advance one state per cycle, return to IDLE after the last row
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        if (state_q == CLEAR) begin
            clr_we    = 1'b1;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) begin
                state_d = IDLE;
            end
        end
    end

    // FSM state and sweep pointer; reset (re)starts the sweep at row 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign busy_w = (state_q == CLEAR);
`else
    assign busy_w = 1'b0;
`endif

    assign busy = busy_w;

    // Request qualification: enable, not sweeping, not in reset
    always_comb begin
        wr_acc = en & wr_en & ~busy_w & ~rst;
        rd_acc = en & rd_en & ~busy_w & ~rst;
    end

    // Table storage: single-entry writes, plus whole-row zeroing during a clear sweep
    always_ff @(posedge clk) begin
`ifdef QRAM_CLEAR_EN
        if (clr_we && !rst) begin
            for (int unsigned k = 0; k < N_ACT; k++) begin
                mem_q[clr_ptr_q][ACT_W'(k)] <= '0;
            end
        end
`endif
        if (wr_acc) begin
            mem_q[wr_addr][wr_act] <= wr_data;
        end
    end

    // S1 row fetch; a same-cycle write to the fetched state forwards its value (write-first)
    always_comb begin
        s1_valid_d = rd_acc;
        for (int unsigned k = 0; k < N_ACT; k++) begin
            s1_row_d[ACT_W'(k)] = s1_row_q[ACT_W'(k)];
            if (rd_acc) begin
                if (wr_acc && (wr_addr == rd_addr) && (wr_act == ACT_W'(k))) begin
                    s1_row_d[ACT_W'(k)] = wr_data;
                end else begin
                    s1_row_d[ACT_W'(k)] = mem_q[rd_addr][ACT_W'(k)];
                end
            end
        end
    end

    // Signed argmax over the S1 row; strict compare keeps the lowest index on ties
    always_comb begin
        max_val_c = s1_row_q[0];
        max_act_c = '0;
        for (int unsigned k = 1; k < N_ACT; k++) begin
            if (s1_row_q[ACT_W'(k)] > max_val_c) begin
                max_val_c = s1_row_q[ACT_W'(k)];
                max_act_c = ACT_W'(k);
            end
        end
    end

    // S2 result: load on a valid S1 entry, otherwise hold the previous result
    always_comb begin
        rd_valid_d   = s1_valid_q;
        rd_data_d    = rd_data_q;
        rd_max_val_d = rd_max_val_q;
        rd_max_act_d = rd_max_act_q;
        if (s1_valid_q) begin
            for (int unsigned k = 0; k < N_ACT; k++) begin
                rd_data_d[k*DATA_W +: DATA_W] = s1_row_q[ACT_W'(k)];
            end
            rd_max_val_d = max_val_c;
            rd_max_act_d = max_act_c;
        end
    end

    // S1 row register; only reloaded on an accepted read
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < N_ACT; k++) begin
            s1_row_q[ACT_W'(k)] <= s1_row_d[ACT_W'(k)];
        end
    end

    // Pipeline control and output registers, flushed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_max_val_q <= '0;
            rd_max_act_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_max_val_q <= rd_max_val_d;
            rd_max_act_q <= rd_max_act_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rd_max_val = rd_max_val_q;
    assign rd_max_act = rd_max_act_q;

endmodule

// File: tb/tb_q_table_ram.sv
// Testbench for q_table_ram: directed steps with a scoreboard of expected
// read results (row, argmax, return cycle) checked when rd_valid pulses.
module tb_q_table_ram;

    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int NA    = 4;
    localparam int ACTW  = 2;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [ACTW-1:0]  wr_act;
    logic [DW-1:0]    wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;
    logic [NA*DW-1:0] rd_data;
    logic [DW-1:0]    rd_max_val;
    logic [ACTW-1:0]  rd_max_act;
    logic             busy;

    q_table_ram #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .N_ACT  (NA),
        .ACT_W  (ACTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_act     (wr_act),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_max_val (rd_max_val),
        .rd_max_act (rd_max_act),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NA*DW-1:0] data;
        logic [DW-1:0]    mv;
        logic [ACTW-1:0]  ma;
        int               c;
    } exp_t;

    exp_t           sb[$];
    logic [DW-1:0]  model [DEPTH][NA];
    logic           exp_busy = 1'b0;
    int             cyc = 0;
    int             errors = 0;
    int             checks = 0;

    logic                        have_last = 1'b0;
    logic [NA*DW+DW+ACTW-1:0]    last_all;

    always @(posedge clk) cyc++;

    function automatic exp_t mk(input int a);
        exp_t e;
        e.data = '0;
        for (int k = 0; k < NA; k++) e.data[k*DW +: DW] = model[a][k];
        e.mv = model[a][0];
        e.ma = '0;
        for (int k = 1; k < NA; k++) begin
            if ($signed(model[a][k]) > $signed(e.mv)) begin
                e.mv = model[a][k];
                e.ma = ACTW'(k);
            end
        end
        e.c = cyc + 2;
        return e;
    endfunction

    task automatic step(input logic e, input logic we, input logic [AW-1:0] wa,
                        input logic [ACTW-1:0] wact, input logic [DW-1:0] wd,
                        input logic re, input logic [AW-1:0] ra);
        en = e; wr_en = we; wr_addr = wa; wr_act = wact; wr_data = wd;
        rd_en = re; rd_addr = ra;
        if (e && we && !exp_busy && !rst) model[wa][wact] = wd;
        if (e && re && !exp_busy && !rst) sb.push_back(mk(int'(ra)));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Scoreboard consumer and output-hold checker, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            have_last = 1'b0;
        end else if (rd_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid observed=1 expected=0 cyc=%0d", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (rd_data === e.data) else begin
                    errors++;
                    $error("FAIL rd_data observed=%h expected=%h", rd_data, e.data);
                end
                checks++;
                assert (rd_max_val === e.mv) else begin
                    errors++;
                    $error("FAIL rd_max_val observed=%h expected=%h", rd_max_val, e.mv);
                end
                checks++;
                assert (rd_max_act === e.ma) else begin
                    errors++;
                    $error("FAIL rd_max_act observed=%0d expected=%0d", rd_max_act, e.ma);
                end
                checks++;
                assert (cyc === e.c) else begin
                    errors++;
                    $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, e.c);
                end
            end
            last_all  = {rd_data, rd_max_val, rd_max_act};
            have_last = 1'b1;
        end else if (have_last) begin
            checks++;
            assert ({rd_data, rd_max_val, rd_max_act} === last_all) else begin
                errors++;
                $error("FAIL hold observed=%h expected=%h", {rd_data, rd_max_val, rd_max_act}, last_all);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // reset state
        checks++;
        assert ({rd_valid, rd_data, rd_max_val, rd_max_act} === '0) else begin
            errors++;
            $error("FAIL reset_outputs observed=%h expected=0", {rd_valid, rd_data, rd_max_val, rd_max_act});
        end
`ifdef QRAM_CLEAR_EN
        checks++;
        assert (busy === 1'b1) else begin
            errors++;
            $error("FAIL reset_busy observed=%b expected=1", busy);
        end
        exp_busy = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            idle(1);
            n++;
        end
        exp_busy = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < NA; k++) model[a][k] = '0;
`else
        checks++;
        assert (busy === 1'b0) else begin
            errors++;
            $error("FAIL reset_busy observed=%b expected=0", busy);
        end
`endif

        // fill the whole table so every later read is defined
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < NA; k++)
                step(1'b1, 1'b1, AW'(a), ACTW'(k), 16'($urandom), 1'b0, '0);

        // row 5 = 10,-3,7,10 ; tie on the maximum -> action 0
        step(1'b1, 1'b1, 6'd5, 2'd0, 16'd10, 1'b0, '0);
        step(1'b1, 1'b1, 6'd5, 2'd1, 16'hFFFD, 1'b0, '0);
        step(1'b1, 1'b1, 6'd5, 2'd2, 16'd7, 1'b0, '0);
        step(1'b1, 1'b1, 6'd5, 2'd3, 16'd10, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd5);
        idle(3);

        // same-cycle write and read on a zeroed row: write-first forwarding
        for (int k = 0; k < NA; k++) step(1'b1, 1'b1, 6'd9, ACTW'(k), 16'd0, 1'b0, '0);
        step(1'b1, 1'b1, 6'd9, 2'd2, 16'h7FFF, 1'b1, 6'd9);
        idle(3);

        // back-to-back reads with no bubbles
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd1);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd2);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd3);
        idle(3);

        // en=0 drops the request, but the one accepted before still returns
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd3);
        step(1'b0, 1'b1, 6'd3, 2'd1, 16'h1111, 1'b1, 6'd4);
        idle(4);

        // all-negative row
        step(1'b1, 1'b1, 6'd12, 2'd0, 16'hFFFF, 1'b0, '0);
        step(1'b1, 1'b1, 6'd12, 2'd1, 16'h8000, 1'b0, '0);
        step(1'b1, 1'b1, 6'd12, 2'd2, 16'hFFFE, 1'b0, '0);
        step(1'b1, 1'b1, 6'd12, 2'd3, 16'hFFFB, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd12);
        // write landing after the row was captured is not seen by that read
        step(1'b1, 1'b1, 6'd12, 2'd1, 16'h0100, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd12);
        idle(3);

        // top-of-range address and last action
        step(1'b1, 1'b1, 6'd63, 2'd3, 16'h7FFF, 1'b1, 6'd63);
        idle(3);

        // random mixed traffic
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 7) != 0), 1'($urandom), 6'($urandom), 2'($urandom),
                 16'($urandom), 1'($urandom), 6'($urandom));
        idle(4);

`ifdef QRAM_CLEAR_EN
        // clear sweep: busy for DEPTH cycles, writes dropped, rows read back as zero
        rst = 1'b1;
        exp_busy = 1'b1;
        idle(1);
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (n == 3) step(1'b1, 1'b1, 6'd5, 2'd0, 16'h1234, 1'b1, 6'd5);
            else idle(1);
            n++;
        end
        checks++;
        assert (n === DEPTH) else begin
            errors++;
            $error("FAIL busy_len observed=%0d expected=%0d", n, DEPTH);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(30);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            idle(1);
            n++;
        end
        checks++;
        assert (n === DEPTH) else begin
            errors++;
            $error("FAIL busy_restart_len observed=%0d expected=%0d", n, DEPTH);
        end
        exp_busy = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            for (int k = 0; k < NA; k++) model[a][k] = '0;
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd5);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd0);
        step(1'b1, 1'b0, '0, '0, '0, 1'b1, 6'd63);
        idle(4);
`endif

        // every expected read must have come back
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL pending_reads observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
